// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: walks regfile addresses through one read port and streams each word out over valid/ready.
module reg_dump_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr_w,
  input  logic [DATA_W-1:0] rd_data_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(SKIP_ZERO != 0);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d, index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                accept, capture, finish;
  always_comb begin
    accept  = state_q == SEND && out_ready;
    capture = !abort && (state_q == IDLE ? start : accept && index_q != LAST);
    finish  = !abort && accept && index_q == LAST;
    state_d = abort || finish ? IDLE : capture ? SEND : state_q;
    // pointer saturates on the last register so the port never shows a wrapped address
    ptr_d   = abort || finish ? FIRST : capture ? (ptr_q == LAST ? ptr_q : ptr_q + ADDR_W'(1)) : ptr_q;
    data_d  = capture ? rd_data_r : data_q;
    index_d = capture ? ptr_q : index_q;
    done_d  = finish;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= FIRST;
      data_q  <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      index_q <= index_d;
      done_q  <= done_d;
    end
  end
  assign rd_addr_w = ptr_q;
  assign out_valid = state_q == SEND;
  assign busy      = state_q == SEND;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = out_valid && index_q == LAST;
  assign done      = done_q;
endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl: two instances (SKIP_ZERO 0 and 1) driven in lockstep and checked against an index-counting model.
module tb_reg_dump_ctrl;
  logic        clk = 1'b0, rst_n, start, abort, out_ready;
  logic [4:0]  rd_addr0, rd_addr1, idx0, idx1;
  logic [31:0] rd_data0, rd_data1, data0, data1;
  logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;
  logic [31:0] regs [32];
  int          total = 0, bad = 0;
  int          cur [2];
  bit          dexp [2];
  int          first [2] = '{0, 1};

  typedef struct {
    bit s, a, r;
    bit ev;
    int eidx;
    bit ed;
  } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;
  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

  reg_dump_ctrl #(.SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rd_addr_w(rd_addr0),
    .rd_data_r(rd_data0), .out_valid(valid0), .out_ready(out_ready), .out_data(data0),
    .out_index(idx0), .out_last(last0), .busy(busy0), .done(done0));
  reg_dump_ctrl #(.SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rd_addr_w(rd_addr1),
    .rd_data_r(rd_data1), .out_valid(valid1), .out_ready(out_ready), .out_data(data1),
    .out_index(idx1), .out_last(last1), .busy(busy1), .done(done1));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < 2; j++) begin
      logic v, b, d, l;
      logic [4:0] ix, ra;
      logic [31:0] dt;
      bit act;
      v  = j ? valid1 : valid0;
      b  = j ? busy1 : busy0;
      d  = j ? done1 : done0;
      l  = j ? last1 : last0;
      ix = j ? idx1 : idx0;
      ra = j ? rd_addr1 : rd_addr0;
      dt = j ? data1 : data0;
      act = cur[j] >= 0;
      chk($sformatf("valid%0d", j), 32'(v), 32'(act));
      chk($sformatf("busy%0d", j), 32'(b), 32'(act));
      chk($sformatf("done%0d", j), 32'(d), 32'(dexp[j]));
      chk($sformatf("rd_addr%0d", j), 32'(ra), act ? 32'(cur[j] == 31 ? 31 : cur[j] + 1) : 32'(first[j]));
      chk($sformatf("last%0d", j), 32'(l), 32'(act && cur[j] == 31));
      if (act) begin
        chk($sformatf("index%0d", j), 32'(ix), 32'(cur[j]));
        chk($sformatf("data%0d", j), dt, regs[cur[j]]);
      end
    end
  endtask

  // Model: each instance is either idle (-1) or presenting register cur; a dump walks first..31.
  task automatic step(bit s, bit a, bit r);
    start = s; abort = a; out_ready = r;
    for (int j = 0; j < 2; j++) begin
      dexp[j] = 1'b0;
      if (cur[j] < 0) begin
        if (s && !a) cur[j] = first[j];
      end else if (a) cur[j] = -1;
      else if (r) begin
        if (cur[j] == 31) begin cur[j] = -1; dexp[j] = 1'b1; end
        else cur[j]++;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur = '{-1, -1};
    dexp = '{0, 0};
    check_all();
  endtask

  initial begin
    int n0, n1, beats0, k;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | i;
    vecs[0] = '{1, 1, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 1, 0, 0};
    vecs[3] = '{1, 0, 0, 1, 0, 0};
    vecs[4] = '{0, 0, 1, 1, 1, 0};
    vecs[5] = '{0, 0, 1, 1, 2, 0};
    vecs[6] = '{0, 1, 1, 0, 2, 0};
    vecs[7] = '{1, 0, 0, 1, 0, 0};
    vecs[8] = '{0, 1, 0, 0, 0, 0};
    do_reset();
    chk("reset_data", data0, 32'h0);
    chk("reset_index", 32'(idx0), 32'h0);
    chk("reset_index_skip", 32'(idx1), 32'h0);

    // directed: start&&abort in IDLE, start ignored while stalled, abort, restart
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].s, vecs[i].a, vecs[i].r);
      chk($sformatf("vec%0d_valid", i), 32'(valid0), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_index", i), 32'(idx0), 32'(vecs[i].eidx));
      chk($sformatf("vec%0d_done", i), 32'(done0), 32'(vecs[i].ed));
      if (vecs[i].ev) chk($sformatf("vec%0d_data", i), data0, 32'hA500_0000 | vecs[i].eidx);
    end

    // full dump with ready held: done timing for both instances
    do_reset();
    n0 = 0; n1 = 0;
    step(1, 0, 1);
    for (int c = 1; c <= 40; c++) begin
      if (done0 && n0 == 0) n0 = c;
      if (done1 && n1 == 0) n1 = c;
      if (n0 != 0 && n1 != 0) break;
      step(0, 0, 1);
    end
    chk("latency_skip0", 32'(n0), 32'd33);
    chk("latency_skip1", 32'(n1), 32'd32);
    step(0, 0, 1);

    // toggling ready: stable while stalled, exactly 32 beats
    beats0 = 0;
    step(1, 0, 0);
    for (int c = 0; c < 200 && (cur[0] >= 0 || cur[1] >= 0); c++) begin
      if (valid0 && c % 2 == 0) beats0++;
      step(0, 0, c % 2 == 0);
    end
    chk("beats_toggle", 32'(beats0), 32'd32);

    // abort after index 5 accepted, then restart from r[0]
    step(1, 0, 1);
    k = 0;
    while (cur[0] != 6 && k < 50) begin step(0, 0, 1); k++; end
    step(0, 1, 1);
    chk("abort_valid", 32'(valid0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    step(1, 0, 0);
    chk("restart_index", 32'(idx0), 32'd0);
    chk("restart_data", data0, regs[0]);
    step(0, 1, 0);

    // async reset mid-dump at index 10
    step(1, 0, 1);
    k = 0;
    while (cur[0] != 10 && k < 50) begin step(0, 0, 1); k++; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    chk("arst_index", 32'(idx0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = '{-1, -1};
    dexp = '{0, 0};
    step(1, 0, 1);
    chk("after_rst_index", 32'(idx0), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (cur[0] < 0 && cur[1] < 0 && $urandom_range(3) == 0)
        regs[$urandom_range(31)] = $urandom;
      step($urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
